// File: rtl/multicycle_maindec.sv
// Main-control FSM for the multicycle MIPS datapath: sequences fetch/decode/execute/memory/writeback,
// stalls on mem_ready, traps illegal opcodes and counts retired instructions.
module multicycle_maindec #(
  parameter int unsigned ALUOP_W         = 3,
  parameter int unsigned CNT_W           = 32,
  parameter bit          TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [5:0]         op,
  input  logic               mem_ready,
  output logic               pcwrite,
  output logic               irwrite,
  output logic               memwrite,
  output logic               regwrite,
  output logic               iord,
  output logic               alusrca,
  output logic               memtoreg,
  output logic               regdst,
  output logic [1:0]         alusrcb,
  output logic [1:0]         pcsrc,
  output logic               branch,
  output logic               branch_ne,
  output logic               zeroext,
  output logic [ALUOP_W-1:0] aluop,
  output logic               illegal,
  output logic [CNT_W-1:0]   instret
);

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpBne   = 6'b000101;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpOri   = 6'b001101;
  localparam logic [5:0] OpAndi  = 6'b001100;
  localparam logic [5:0] OpJ     = 6'b000010;

  localparam logic [2:0] AluAdd   = 3'd0;
  localparam logic [2:0] AluSub   = 3'd1;
  localparam logic [2:0] AluOr    = 3'd2;
  localparam logic [2:0] AluAnd   = 3'd3;
  localparam logic [2:0] AluFunct = 3'd4;

  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  typedef enum logic [3:0] {
    StFetch, StDecode, StMemAdr, StMemRd, StMemWb, StMemWr, StExec,
    StAluWb, StBranch, StIExec, StIWb, StJump, StIllegal
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             retire;
  logic [2:0]       aluop_n;
  logic             imm_logical;

  // ORI/ANDI take a zero-extended immediate in both the execute and writeback cycles.
  assign imm_logical = (op == OpOri) || (op == OpAndi);

  always_comb begin
    state_d   = state_q;
    retire    = 1'b0;
    pcwrite   = 1'b0;
    irwrite   = 1'b0;
    memwrite  = 1'b0;
    regwrite  = 1'b0;
    iord      = 1'b0;
    alusrca   = 1'b0;
    memtoreg  = 1'b0;
    regdst    = 1'b0;
    alusrcb   = 2'b00;
    pcsrc     = 2'b00;
    branch    = 1'b0;
    branch_ne = 1'b0;
    zeroext   = 1'b0;
    aluop_n   = AluAdd;
    illegal   = 1'b0;
    case (state_q)
      StFetch: begin
        alusrcb = 2'b01;
        irwrite = mem_ready;
        pcwrite = mem_ready;
        if (mem_ready) state_d = StDecode;
      end
      StDecode: begin
        alusrcb = 2'b11;
        case (op)
          OpRtype:               state_d = StExec;
          OpLw, OpSw:            state_d = StMemAdr;
          OpBeq, OpBne:          state_d = StBranch;
          OpAddi, OpOri, OpAndi: state_d = StIExec;
          OpJ:                   state_d = StJump;
          default: begin
            if (TRAP_ON_ILLEGAL) begin
              state_d = StIllegal;
            end else begin
              state_d = StFetch;
              retire  = 1'b1;
            end
          end
        endcase
      end
      StMemAdr: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = (op == OpLw) ? StMemRd : StMemWr;
      end
      StMemRd: begin
        iord = 1'b1;
        if (mem_ready) state_d = StMemWb;
      end
      StMemWb: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
        state_d  = StFetch;
        retire   = 1'b1;
      end
      StMemWr: begin
        iord     = 1'b1;
        memwrite = mem_ready;
        if (mem_ready) begin
          state_d = StFetch;
          retire  = 1'b1;
        end
      end
      StExec: begin
        alusrca = 1'b1;
        aluop_n = AluFunct;
        state_d = StAluWb;
      end
      StAluWb: begin
        regwrite = 1'b1;
        regdst   = 1'b1;
        state_d  = StFetch;
        retire   = 1'b1;
      end
      StBranch: begin
        alusrca   = 1'b1;
        aluop_n   = AluSub;
        branch    = 1'b1;
        branch_ne = (op == OpBne);
        pcsrc     = 2'b01;
        state_d   = StFetch;
        retire    = 1'b1;
      end
      StIExec: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        zeroext = imm_logical;
        if (op == OpOri)       aluop_n = AluOr;
        else if (op == OpAndi) aluop_n = AluAnd;
        state_d = StIWb;
      end
      StIWb: begin
        regwrite = 1'b1;
        zeroext  = imm_logical;
        state_d  = StFetch;
        retire   = 1'b1;
      end
      StJump: begin
        pcwrite = 1'b1;
        pcsrc   = 2'b10;
        state_d = StFetch;
        retire  = 1'b1;
      end
      StIllegal: illegal = 1'b1;
      default:   state_d = StFetch;
    endcase
  end

  assign aluop     = ALUOP_W'(aluop_n);
  assign instret_d = retire ? instret_q + CntOne : instret_q;
  assign instret   = instret_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StFetch;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

endmodule

// File: tb/tb_multicycle_maindec.sv
// Bench for multicycle_maindec: table of per-opcode cycle counts, hand-written stall/trap/wrap/reset
// sequences, and random traffic checked every cycle against a per-instruction step-plan model.
module tb_multicycle_maindec;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n, mem_ready;
  logic [5:0] op;

  logic pcwrite, irwrite, memwrite, regwrite, iord, alusrca, memtoreg, regdst;
  logic branch, branch_ne, zeroext, illegal;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] aluop;
  logic [31:0] instret;

  logic n_pcwrite, n_irwrite, n_memwrite, n_regwrite, n_iord, n_alusrca, n_memtoreg, n_regdst;
  logic n_branch, n_branch_ne, n_zeroext, n_illegal;
  logic [1:0] n_alusrcb, n_pcsrc;
  logic [2:0] n_aluop;
  logic [31:0] n_instret;

  logic c_pcwrite, c_irwrite, c_memwrite, c_regwrite, c_iord, c_alusrca, c_memtoreg, c_regdst;
  logic c_branch, c_branch_ne, c_zeroext, c_illegal;
  logic [1:0] c_alusrcb, c_pcsrc;
  logic [2:0] c_aluop;
  logic [3:0] c_instret;

  multicycle_maindec dut (
    .clk(clk), .reset_n(reset_n), .op(op), .mem_ready(mem_ready),
    .pcwrite(pcwrite), .irwrite(irwrite), .memwrite(memwrite), .regwrite(regwrite),
    .iord(iord), .alusrca(alusrca), .memtoreg(memtoreg), .regdst(regdst),
    .alusrcb(alusrcb), .pcsrc(pcsrc), .branch(branch), .branch_ne(branch_ne),
    .zeroext(zeroext), .aluop(aluop), .illegal(illegal), .instret(instret)
  );

  multicycle_maindec #(.TRAP_ON_ILLEGAL(1'b0)) dut_nt (
    .clk(clk), .reset_n(reset_n), .op(op), .mem_ready(mem_ready),
    .pcwrite(n_pcwrite), .irwrite(n_irwrite), .memwrite(n_memwrite), .regwrite(n_regwrite),
    .iord(n_iord), .alusrca(n_alusrca), .memtoreg(n_memtoreg), .regdst(n_regdst),
    .alusrcb(n_alusrcb), .pcsrc(n_pcsrc), .branch(n_branch), .branch_ne(n_branch_ne),
    .zeroext(n_zeroext), .aluop(n_aluop), .illegal(n_illegal), .instret(n_instret)
  );

  multicycle_maindec #(.CNT_W(4)) dut_c4 (
    .clk(clk), .reset_n(reset_n), .op(op), .mem_ready(mem_ready),
    .pcwrite(c_pcwrite), .irwrite(c_irwrite), .memwrite(c_memwrite), .regwrite(c_regwrite),
    .iord(c_iord), .alusrca(c_alusrca), .memtoreg(c_memtoreg), .regdst(c_regdst),
    .alusrcb(c_alusrcb), .pcsrc(c_pcsrc), .branch(c_branch), .branch_ne(c_branch_ne),
    .zeroext(c_zeroext), .aluop(c_aluop), .illegal(c_illegal), .instret(c_instret)
  );

  logic [18:0] act_vec, nt_vec, c4_vec;
  assign act_vec = {pcwrite, irwrite, memwrite, regwrite, iord, alusrca, memtoreg, regdst,
                    alusrcb, pcsrc, branch, branch_ne, zeroext, aluop, illegal};
  assign nt_vec  = {n_pcwrite, n_irwrite, n_memwrite, n_regwrite, n_iord, n_alusrca, n_memtoreg,
                    n_regdst, n_alusrcb, n_pcsrc, n_branch, n_branch_ne, n_zeroext, n_aluop,
                    n_illegal};
  assign c4_vec  = {c_pcwrite, c_irwrite, c_memwrite, c_regwrite, c_iord, c_alusrca, c_memtoreg,
                    c_regdst, c_alusrcb, c_pcsrc, c_branch, c_branch_ne, c_zeroext, c_aluop,
                    c_illegal};

  int checks = 0;
  int failures = 0;

  // Model: each instruction is a string of steps; F/R/S repeat while memory is not ready.
  byte         plan[$];
  logic [31:0] m_instret;
  bit          others_sync;
  logic        obs_memwrite;

  typedef struct {
    logic [5:0] op;
    int         cycles;
    string      name;
  } vec_t;
  vec_t vecs[9];

  function automatic string plan_for(input logic [5:0] o);
    case (o)
      6'd0:           return "FDEW";
      6'd35:          return "FDARM";
      6'd43:          return "FDAS";
      6'd4, 6'd5:     return "FDB";
      6'd8, 6'd12, 6'd13: return "FDIK";
      6'd2:           return "FDJ";
      default:        return "FDX";
    endcase
  endfunction

  function automatic logic [18:0] exp_outs(input byte s, input logic [5:0] o, input bit mr);
    logic pcw, irw, mw, rw, io, asa, mtr, rd, br, bne, ze, il;
    logic [1:0] asb, ps;
    logic [2:0] ao;
    {pcw, irw, mw, rw, io, asa, mtr, rd, br, bne, ze, il} = '0;
    asb = 2'd0; ps = 2'd0; ao = 3'd0;
    case (s)
      "F": begin asb = 2'd1; pcw = mr; irw = mr; end
      "D": asb = 2'd3;
      "A": begin asa = 1'b1; asb = 2'd2; end
      "R": io = 1'b1;
      "M": begin rw = 1'b1; mtr = 1'b1; end
      "S": begin io = 1'b1; mw = mr; end
      "E": begin asa = 1'b1; ao = 3'd4; end
      "W": begin rw = 1'b1; rd = 1'b1; end
      "B": begin asa = 1'b1; ao = 3'd1; br = 1'b1; ps = 2'd1; bne = (o == 6'd5); end
      "I": begin
        asa = 1'b1; asb = 2'd2; ze = (o == 6'd12) || (o == 6'd13);
        ao = (o == 6'd13) ? 3'd2 : (o == 6'd12) ? 3'd3 : 3'd0;
      end
      "K": begin rw = 1'b1; ze = (o == 6'd12) || (o == 6'd13); end
      "J": begin pcw = 1'b1; ps = 2'd2; end
      "X": il = 1'b1;
      default: ;
    endcase
    return {pcw, irw, mw, rw, io, asa, mtr, rd, asb, ps, br, bne, ze, ao, il};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called 1 time unit after a rising edge; returns 1 time unit after the next one.
  task automatic run_cycle(input bit mr);
    byte s;
    string p;
    logic [18:0] e;
    mem_ready = mr;
    if (plan.size() == 0) begin
      p = plan_for(op);
      for (int i = 0; i < p.len(); i++) plan.push_back(p[i]);
    end
    s = plan[0];
    #3;
    e = exp_outs(s, op, mr);
    obs_memwrite = memwrite;
    chk($sformatf("outs step %c op %0d mr %0d", s, op, mr), 64'(act_vec), 64'(e));
    chk("instret", 64'(instret), 64'(m_instret));
    if (others_sync) begin
      chk($sformatf("nt outs step %c", s), 64'(nt_vec), 64'(e));
      chk("nt instret", 64'(n_instret), 64'(m_instret));
      chk($sformatf("c4 outs step %c", s), 64'(c4_vec), 64'(e));
      chk("c4 instret", 64'(c_instret), 64'(m_instret[3:0]));
    end
    @(posedge clk);
    #1;
    if (s == "X") begin
    end else if ((s == "F" || s == "R" || s == "S") && !mr) begin
    end else begin
      plan.delete(0);
      if (plan.size() == 0) m_instret++;
    end
  endtask

  task automatic run_instr(input logic [5:0] o, input bit rnd);
    int n;
    op = o;
    n = 0;
    do begin
      run_cycle(rnd ? ($urandom_range(3) != 0) : 1'b1);
      n++;
    end while (plan.size() != 0 && n < 64);
    if (n >= 64) chk("instr timeout", 64'(n), 64'(0));
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    chk("reset outs", 64'(act_vec), 64'(exp_outs("F", op, mem_ready)));
    chk("reset nt outs", 64'(nt_vec), 64'(exp_outs("F", op, mem_ready)));
    chk("reset c4 outs", 64'(c4_vec), 64'(exp_outs("F", op, mem_ready)));
    chk("reset instret", 64'(instret), 64'(0));
    chk("reset nt instret", 64'(n_instret), 64'(0));
    chk("reset c4 instret", 64'(c_instret), 64'(0));
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    plan.delete();
    m_instret = '0;
    others_sync = 1'b1;
  endtask

  initial begin
    logic [5:0] legal_ops[9];
    bit mrs[7];
    logic [31:0] r0, nt0;
    int n, wcount;

    vecs[0] = '{6'd35, 5, "lw"};   vecs[1] = '{6'd43, 4, "sw"};
    vecs[2] = '{6'd0,  4, "rtype"}; vecs[3] = '{6'd8,  4, "addi"};
    vecs[4] = '{6'd13, 4, "ori"};  vecs[5] = '{6'd12, 4, "andi"};
    vecs[6] = '{6'd4,  3, "beq"};  vecs[7] = '{6'd5,  3, "bne"};
    vecs[8] = '{6'd2,  3, "j"};
    legal_ops = '{6'd0, 6'd35, 6'd43, 6'd4, 6'd5, 6'd8, 6'd13, 6'd12, 6'd2};
    mrs = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

    reset_n = 1'b1; mem_ready = 1'b1; op = 6'd0; m_instret = '0; others_sync = 1'b0;
    obs_memwrite = 1'b0;
    #2 reset_n = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // Cycles per instruction, measured from the DUT's own instret.
    foreach (vecs[k]) begin
      op = vecs[k].op;
      r0 = instret;
      n = 0;
      do begin
        run_cycle(1'b1);
        n++;
      end while (instret == r0 && n < 20);
      chk($sformatf("cycles %s", vecs[k].name), 64'(n), 64'(vecs[k].cycles));
    end

    // SW stalled three cycles in MEMWR: one write pulse, seven cycles total.
    op = 6'd43;
    r0 = instret;
    wcount = 0;
    for (int i = 0; i < 7; i++) begin
      run_cycle(mrs[i]);
      if (obs_memwrite) wcount++;
      if (i == 5) chk("sw not retired at 6", 64'(instret), 64'(r0));
    end
    chk("sw memwrite pulses", 64'(wcount), 64'(1));
    chk("sw retired at 7", 64'(instret), 64'(r0 + 1));

    for (int i = 0; i < 300; i++) run_instr(legal_ops[$urandom_range(8)], 1'b1);

    // Illegal opcode: main traps, the non-trapping copy retires it as a NOP.
    others_sync = 1'b0;
    op = 6'h3f;
    nt0 = n_instret;
    run_cycle(1'b1);
    run_cycle(1'b1);
    chk("nt illegal retired", 64'(n_instret), 64'(nt0 + 1));
    chk("nt back in fetch", 64'(n_irwrite), 64'(1));
    for (int i = 0; i < 20; i++) run_cycle($urandom_range(1) != 0);
    chk("illegal held", 64'(illegal), 64'(1));
    do_reset();

    for (int i = 0; i < 16; i++) begin
      run_instr(6'd2, 1'b0);
      if (i == 14) chk("c4 instret 15", 64'(c_instret), 64'(15));
    end
    chk("c4 wrap", 64'(c_instret), 64'(0));
    chk("instret 16", 64'(instret), 64'(16));

    // Reset while an R-type sits in EXEC aborts it without retiring.
    op = 6'd0;
    run_cycle(1'b1);
    run_cycle(1'b1);
    do_reset();
    run_instr(6'd0, 1'b0);
    chk("instret after reset rtype", 64'(instret), 64'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_maindec.md
# multicycle_maindec

Parametrised main-control FSM for the multicycle MIPS datapath, successor to the single-cycle combinational main decoder. It sequences each instruction through fetch, decode, execute, memory and write-back states, with memory wait-state handshaking, an illegal-opcode trap, and a retired-instruction counter. It sits between the instruction register's opcode field and the multicycle datapath's enables and muxes, alongside the existing ALU decoder that consumes `aluop`.

## Interface
- `ALUOP_W`, 3: width of `aluop`, must be ≥3. Upper bits are zero-filled.
- `CNT_W`, 32: width of `instret`.
- `TRAP_ON_ILLEGAL`, 1: 1 means an illegal opcode locks in ILLEGAL; 0 means it retires as a NOP.
- `clk` input 1: single clock. All state changes on its rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `op` input 6: opcode from the instruction register. Stable from DECODE until the next FETCH.
- `mem_ready` input 1: memory completes the access this cycle.
- `pcwrite`, `irwrite`, `memwrite`, `regwrite` output 1: register and memory write enables.
- `iord`, `alusrca`, `memtoreg`, `regdst` output 1: datapath mux selects.
- `alusrcb` output 2: 00 reg B, 01 const 4, 10 imm, 11 imm<<2.
- `pcsrc` output 2: 00 ALU result, 01 ALUOut, 10 jump target.
- `branch` output 1: conditional PC write.
- `branch_ne` output 1: invert the zero test (BNE).
- `zeroext` output 1: zero-extend the immediate (ORI/ANDI).
- `aluop` output ALUOP_W: 0 add, 1 sub, 2 or, 3 and, 4 use funct.
- `illegal` output 1: FSM is in ILLEGAL.
- `instret` output CNT_W: count of retired instructions.

## Operation
State register is 4 bits: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, IEXEC, IWB, JUMP, ILLEGAL.

Outputs are Moore, decoded from state. Exceptions: the FETCH/MEMRD/MEMWR enables are gated by `mem_ready`, and IEXEC `aluop`/`zeroext` depend on `op`. Every output not listed for a state is 0.

Per-state outputs and transitions:
- FETCH: `alusrcb`=01, `aluop`=add.
  - `irwrite`=`pcwrite`=`mem_ready`.
  - Go to DECODE when `mem_ready`, else hold.
- DECODE: `alusrcb`=11, `aluop`=add. Next state by `op`:
  - 000000 → EXEC
  - 100011, 101011 → MEMADR
  - 000100, 000101 → BRANCH
  - 001000, 001101, 001100 → IEXEC
  - 000010 → JUMP
  - any other → ILLEGAL if TRAP_ON_ILLEGAL, else FETCH (retires).
- MEMADR: `alusrca`=1, `alusrcb`=10, `aluop`=add. Go to MEMRD for LW, MEMWR for SW.
- MEMRD: `iord`=1. Go to MEMWB when `mem_ready`, else hold.
- MEMWB: `regwrite`=1, `memtoreg`=1. Go to FETCH (retires).
- MEMWR: `iord`=1, `memwrite`=`mem_ready`. Go to FETCH (retires) when `mem_ready`, else hold.
- EXEC: `alusrca`=1, `aluop`=funct. Go to ALUWB.
- ALUWB: `regwrite`=1, `regdst`=1. Go to FETCH (retires).
- BRANCH: `alusrca`=1, `aluop`=sub, `branch`=1, `pcsrc`=01.
  - `branch_ne`=1 when `op`=000101.
  - Go to FETCH (retires).
- IEXEC: `alusrca`=1, `alusrcb`=10.
  - `aluop`: add for ADDI, or for ORI, and for ANDI.
  - `zeroext`=1 for ORI/ANDI.
  - Go to IWB.
- IWB: `regwrite`=1, `regdst`=0. Same `zeroext` as IEXEC. Go to FETCH (retires).
- JUMP: `pcwrite`=1, `pcsrc`=10. Go to FETCH (retires).
- ILLEGAL: `illegal`=1. Hold until reset.

`instret` increments by 1 on every retiring transition into FETCH. It wraps modulo 2^CNT_W with no saturation or flag.

## Timing
- `reset_n` low, asynchronous: state goes to FETCH and `instret` to 0 immediately.
  - Outputs then equal FETCH decode: `memwrite`=`regwrite`=`illegal`=0.
  - `irwrite`/`pcwrite` follow `mem_ready`; the datapath must ignore them while in reset.
- Reset mid-instruction aborts it; no retirement is counted.
- Reset deassertion is expected synchronised externally. The first FETCH edge follows the first `clk` rise after deassertion.
- Cycles per instruction with `mem_ready`=1 throughout:
  - LW 5
  - SW, R-type, ADDI, ORI, ANDI 4
  - BEQ, BNE, J 3
- Each cycle `mem_ready`=0 in FETCH, MEMRD or MEMWR adds exactly one cycle.
- No write enable is asserted during a stalled cycle.
- `mem_ready` is ignored in every other state.

## Test plan
- Reset, then `mem_ready`=1, `op`=100011 → states FETCH, DECODE, MEMADR, MEMRD, MEMWB. `regwrite`=`memtoreg`=1 only in cycle 5; `instret`=1 after cycle 5.
- SW with `mem_ready`=0 for 3 cycles in MEMWR → `memwrite`=0 during the stall, `memwrite`=1 for exactly 1 cycle; total 7 cycles.
- `op`=000101 → BRANCH has `branch`=`branch_ne`=1, `aluop`=1, `pcsrc`=01; `op`=000100 gives `branch_ne`=0.
- `op`=001101, then `op`=001100 → IEXEC `aluop`=2 then 3, `zeroext`=1. `op`=001000 gives `aluop`=0, `zeroext`=0.
- `op`=111111 with TRAP_ON_ILLEGAL=1 → `illegal`=1 held for 20 cycles, `instret` unchanged, `reset_n` pulse clears it. With TRAP_ON_ILLEGAL=0 → back to FETCH after 2 cycles, `instret`+1.
- CNT_W=4, 16 J instructions → `instret` wraps to 0. Assert `reset_n` low mid-R-type → FETCH immediately, `instret`=0.
